// File: rtl/serial_adder_8bit_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Imported by the RTL and the testbench so both agree on the encodings.
package serial_adder_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_8bit_full_adder.sv
// One-bit full adder built from two half adders plus an OR for the carry.
// This cell is the only arithmetic in the serial adder.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_a     (i_a),
    .i_b     (i_b),
    .o_sum   (w_s1),
    .o_carry (w_c1)
  );

  half_adder u_ha1 (
    .i_a     (w_s1),
    .i_b     (i_cin),
    .o_sum   (o_sum),
    .o_carry (w_c2)
  );

  assign o_cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: latches operands on start, adds LSB-first through one full adder
// over WIDTH cycles, then presents a registered Sum/Cout with a one-cycle done strobe.
module serial_adder_8bit
  import serial_adder_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;

  full_adder u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);

  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_SHIFT);
      r_done  <= (w_next_state == ST_DONE);
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= Cin;
        r_cnt   <= '0;
        r_psum  <= '0;
      end else if (r_state == ST_SHIFT) begin
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at position 0.
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_psum  <= {w_s, r_psum[WIDTH-1:1]};
        r_carry <= w_c;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_sum  <= {w_s, r_psum[WIDTH-1:1]};
          r_cout <= w_c;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Sum  = r_sum;
  assign Cout = r_cout;

endmodule
